// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver.
// Rebuilds LSB-first words from an upstream right-shift PISO. A start marker
// qualified by bit_valid frames each word. Completed words are held in an
// output register with a valid/ready handshake. Dropped words set a sticky
// overrun flag, and a restart in the middle of a word pulses frame_err.
module sipo_frame_rx #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun,
  output logic             frame_err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shift_reg;

  // Next-state signals shared by the sequential blocks below.
  logic             start;       // bit_valid with frame_start: begin a new word
  logic             accept;      // this bit joins the word being assembled
  logic             restart;     // a partial word is abandoned by a new start
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] count_next;
  logic             complete;    // this edge accepts the WIDTH-th bit
  logic             consume;     // downstream takes the held word
  logic             load;        // completed word goes into the output register
  logic             drop;        // completed word has nowhere to go

  // Decode this cycle's framing and handshake events.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    start      = 1'b0;
    accept     = 1'b0;
    restart    = 1'b0;
    shift_next = shift_reg;
    count_next = bit_count;
    complete   = 1'b0;
    consume    = out_valid && out_ready;
    load       = 1'b0;
    drop       = 1'b0;

    if (bit_valid) begin
      start   = frame_start;
      accept  = frame_start || (state == SHIFT);
      restart = frame_start && (state == SHIFT);
    end

    if (start) begin
      // The new first bit enters the MSB. Any partial word already in the
      // register is discarded, so its bits cannot leak into the new word.
      shift_next = {serial_in, {(WIDTH-1){1'b0}}};
      count_next = CNT_W'(1);
    end else if (accept) begin
      // Right shift. After WIDTH accepts, the first bit sits at bit 0.
      shift_next = {serial_in, shift_reg[WIDTH-1:1]};
      count_next = bit_count + CNT_W'(1);
    end

    complete = accept && (count_next == CNT_W'(WIDTH));

    if (complete) begin
      if (!out_valid || out_ready) load = 1'b1;
      else                         drop = 1'b1;
    end
  end

  // Framing state, shift register and bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      // NOTE: the shift register is a handful of flops, not a memory array, so it is reset for clean and deterministic state.
      shift_reg <= '0;
      bit_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (complete) begin
        state     <= IDLE;
        shift_reg <= shift_next;
        bit_count <= '0;
      end else if (accept) begin
        state     <= SHIFT;
        shift_reg <= shift_next;
        bit_count <= count_next;
      end
    end
  end

  // Output register with a valid/ready handshake. It does not move while a
  // word waits to be consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
    end else begin
      if (load) begin
        parallel_out <= shift_next;
        out_valid    <= 1'b1;
      end else if (consume) begin
        out_valid    <= 1'b0;
      end
    end
  end

  // Status flags. Overrun is sticky, and a drop beats a clear on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= drop || (overrun && !ovr_clr);
      frame_err <= restart;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Testbench for sipo_frame_rx (WIDTH=4).
// The stimulus pushes each word that should reach the output into a queue.
// A negedge monitor pops one entry each time the DUT presents a new word and
// compares them. Flags are checked directly against hand-computed values.
module tb_sipo_frame_rx;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             serial_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             frame_start = 1'b0;
  logic             out_ready = 1'b0;
  logic             ovr_clr = 1'b0;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;
  logic             frame_err;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             held = 1'b0;

  sipo_frame_rx #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .out_ready    (out_ready),
    .ovr_clr      (ovr_clr),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .bit_count    (bit_count),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: a word is newly presented when out_valid is high and the previous
  // cycle did not hold an unconsumed word.
  always @(negedge clk) begin
    if (rst && out_valid && !held) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_word: got %0h expected none (t=%0t)", parallel_out, $time);
      end else begin
        check("scoreboard_word", 32'(parallel_out), 32'(exp_q.pop_front()));
      end
    end
    held = out_valid && !out_ready;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic fs);
    serial_in   = b;
    bit_valid   = 1'b1;
    frame_start = fs;
    tick(1);
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    serial_in   = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) send_bit(w[i], i == 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_parallel_out"}, 32'(parallel_out), 32'h0);
    check({tag, "_out_valid"},    32'(out_valid),    32'h0);
    check({tag, "_busy"},         32'(busy),         32'h0);
    check({tag, "_bit_count"},    32'(bit_count),    32'h0);
    check({tag, "_overrun"},      32'(overrun),      32'h0);
    check({tag, "_frame_err"},    32'(frame_err),    32'h0);
  endtask

  initial begin
    // Reset state.
    #2;
    check_all_zero("reset");
    tick(1);
    rst = 1'b1;
    tick(1);
    check_all_zero("after_reset");

    // T1: single word 1101 with out_ready low. It stays presented.
    out_ready = 1'b0;
    exp_q.push_back(4'b1101);
    send_word(4'b1101);
    check("t1_out_valid", 32'(out_valid), 32'h1);
    check("t1_parallel_out", 32'(parallel_out), 32'hD);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_overrun", 32'(overrun), 32'h0);
    tick(3);
    check("t1_still_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("t1_consumed", 32'(out_valid), 32'h0);

    // T2: back-to-back words 1101 and 0110 with out_ready held high.
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b0110);
    send_word(4'b1101);
    check("t2_w0_valid", 32'(out_valid), 32'h1);
    send_bit(1'b0, 1'b1);
    check("t2_w0_window", 32'(out_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t2_w1_valid", 32'(out_valid), 32'h1);
    check("t2_w1_word", 32'(parallel_out), 32'h6);
    tick(1);
    check("t2_w1_window", 32'(out_valid), 32'h0);
    check("t2_overrun", 32'(overrun), 32'h0);
    out_ready = 1'b0;

    // T3: overrun, clear, then a drop and a clear on the same edge.
    do_reset();
    exp_q.push_back(4'b1101);
    send_word(4'b1101);
    send_word(4'b0011);
    check("t3_held_word", 32'(parallel_out), 32'hD);
    check("t3_overrun_set", 32'(overrun), 32'h1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check("t3_overrun_clr", 32'(overrun), 32'h0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    ovr_clr = 1'b1;
    send_bit(1'b0, 1'b0);
    ovr_clr = 1'b0;
    check("t3_set_wins", 32'(overrun), 32'h1);
    check("t3_held_word2", 32'(parallel_out), 32'hD);
    ovr_clr = 1'b1;
    out_ready = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    out_ready = 1'b0;
    check("t3_consumed", 32'(out_valid), 32'h0);

    // T4: restart in the middle of a word.
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(4'b1110);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    check("t4_count_before", 32'(bit_count), 32'h2);
    check("t4_frame_err_idle", 32'(frame_err), 32'h0);
    send_bit(1'b0, 1'b1);
    check("t4_frame_err_pulse", 32'(frame_err), 32'h1);
    check("t4_count_restart", 32'(bit_count), 32'h1);
    check("t4_busy", 32'(busy), 32'h1);
    send_bit(1'b1, 1'b0);
    check("t4_frame_err_end", 32'(frame_err), 32'h0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t4_word", 32'(parallel_out), 32'hE);
    check("t4_out_valid", 32'(out_valid), 32'h1);
    tick(1);
    out_ready = 1'b0;

    // T5: reset during SHIFT aborts the partial word.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    check("t5_busy", 32'(busy), 32'h1);
    check("t5_count", 32'(bit_count), 32'h2);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("t5_in_reset");
    tick(1);
    rst = 1'b1;
    tick(1);
    out_ready = 1'b1;
    exp_q.push_back(4'b0011);
    send_word(4'b0011);
    check("t5_word", 32'(parallel_out), 32'h3);
    tick(2);
    out_ready = 1'b0;

    // T6: completion on the same edge as consumption, then IDLE bits without a start.
    do_reset();
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b0110);
    send_word(4'b1101);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    check("t6_valid_kept", 32'(out_valid), 32'h1);
    check("t6_new_word", 32'(parallel_out), 32'h6);
    check("t6_overrun", 32'(overrun), 32'h0);
    tick(1);
    check("t6_consumed", 32'(out_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t6_idle_busy", 32'(busy), 32'h0);
    check("t6_idle_count", 32'(bit_count), 32'h0);
    check("t6_idle_valid", 32'(out_valid), 32'h0);
    exp_q.push_back(4'b1010);
    send_word(4'b1010);
    check("t6_after_idle_word", 32'(parallel_out), 32'hA);
    tick(3);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
